// File: rtl/wired_rob_alloc.sv
// wired_rob_alloc: compacts up to two decoded instructions per cycle, tags each with a
// circular ROB index and forwards the package through one registered stage.
module wired_rob_alloc #(
    parameter int ROB_DEPTH = 32,
    parameter int PACK_W    = 64,
    localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pkg_valid_i,
    output logic                        pkg_ready_o,
    input  logic [1:0]                  pkg_mask_i,
    input  logic [1:0][PACK_W-1:0]      pkg_i,
    output logic                        alloc_valid_o,
    input  logic                        alloc_ready_i,
    output logic [1:0]                  alloc_mask_o,
    output logic [1:0][PACK_W-1:0]      alloc_o,
    output logic [1:0][IDX_W-1:0]       alloc_rob_id_o,
    input  logic                        commit_valid_i,
    input  logic [1:0]                  commit_cnt_i,
    input  logic                        flush_i,
    output logic [IDX_W:0]              free_cnt_o,
    output logic                        empty_o
);

    logic [IDX_W:0] head_q, tail_q, head_nxt, tail_nxt, count;
    logic [1:0]     need;
    logic           accept;

    assign count       = tail_q - head_q;
    assign free_cnt_o  = (IDX_W+1)'(ROB_DEPTH) - count;
    assign empty_o     = (count == '0);
    // Threshold of two keeps ready independent of the incoming mask.
    assign pkg_ready_o = !flush_i && (!alloc_valid_o || alloc_ready_i) && (free_cnt_o >= (IDX_W+1)'(2));
    assign accept      = pkg_valid_i && pkg_ready_o;
    assign need        = {1'b0, pkg_mask_i[0]} + {1'b0, pkg_mask_i[1]};

    always_comb begin
        head_nxt = head_q + (commit_valid_i ? (IDX_W+1)'(commit_cnt_i) : '0);
        tail_nxt = flush_i ? head_nxt : accept ? tail_q + (IDX_W+1)'(need) : tail_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            alloc_valid_o  <= 1'b0;
            alloc_mask_o   <= '0;
            alloc_o        <= '0;
            alloc_rob_id_o <= '0;
        end else begin
            head_q <= head_nxt;
            tail_q <= tail_nxt;
            if (flush_i) begin
                alloc_valid_o <= 1'b0;
                alloc_mask_o  <= '0;
            end else if (accept) begin
                alloc_valid_o     <= (need != 2'd0);
                alloc_mask_o      <= (need == 2'd2) ? 2'b11 : (need == 2'd1) ? 2'b01 : 2'b00;
                alloc_o[0]        <= (pkg_mask_i == 2'b10) ? pkg_i[1] : pkg_i[0];
                alloc_o[1]        <= pkg_i[1];
                alloc_rob_id_o[0] <= tail_q[IDX_W-1:0];
                alloc_rob_id_o[1] <= tail_q[IDX_W-1:0] + 1'b1;
            end else if (alloc_ready_i) begin
                alloc_valid_o <= 1'b0;
                alloc_mask_o  <= '0;
            end
        end
    end

    commit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        commit_valid_i |-> ((IDX_W+1)'(commit_cnt_i) <= count));

endmodule

// File: tb/tb_wired_rob_alloc.sv
// tb_wired_rob_alloc: randomized and directed checks against a counter-based ROB model.
module tb_wired_rob_alloc;
    localparam int DEPTH = 8;
    localparam int PW    = 32;
    localparam int IW    = 3;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              pkg_valid = 0;
    logic              pkg_ready;
    logic [1:0]        pkg_mask = 0;
    logic [1:0][PW-1:0] pkg = '0;
    logic              alloc_valid;
    logic              alloc_ready = 0;
    logic [1:0]        alloc_mask;
    logic [1:0][PW-1:0] alloc;
    logic [1:0][IW-1:0] alloc_id;
    logic              commit_valid = 0;
    logic [1:0]        commit_cnt = 0;
    logic              flush = 0;
    logic [IW:0]       free_cnt;
    logic              empty;

    int checks = 0;
    int errors = 0;

    // Model: total entries ever allocated / retired; occupancy and next id follow arithmetically.
    int       m_alloc, m_ret;
    bit       m_valid;
    bit [1:0] m_mask;
    logic [PW-1:0] m_d0, m_d1;
    int       m_id0, m_id1;

    wired_rob_alloc #(.ROB_DEPTH(DEPTH), .PACK_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkg_valid_i(pkg_valid), .pkg_ready_o(pkg_ready), .pkg_mask_i(pkg_mask), .pkg_i(pkg),
        .alloc_valid_o(alloc_valid), .alloc_ready_i(alloc_ready), .alloc_mask_o(alloc_mask),
        .alloc_o(alloc), .alloc_rob_id_o(alloc_id),
        .commit_valid_i(commit_valid), .commit_cnt_i(commit_cnt), .flush_i(flush),
        .free_cnt_o(free_cnt), .empty_o(empty)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_alloc = 0; m_ret = 0; m_valid = 0; m_mask = 0; m_d0 = 0; m_d1 = 0; m_id0 = 0; m_id1 = 0;
    endfunction

    function automatic bit m_ready();
        return !flush && (!m_valid || alloc_ready) && (DEPTH - (m_alloc - m_ret) >= 2);
    endfunction

    task automatic tick();
        int n;
        bit acc;
        n = int'(pkg_mask[0]) + int'(pkg_mask[1]);
        acc = pkg_valid && m_ready();
        if (commit_valid) m_ret += int'(commit_cnt);
        if (flush) begin
            m_alloc = m_ret; m_valid = 0; m_mask = 0;
        end else if (acc) begin
            m_valid = (n > 0);
            m_mask  = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
            m_d0    = (pkg_mask == 2'b10) ? pkg[1] : pkg[0];
            m_d1    = pkg[1];
            m_id0   = m_alloc % DEPTH;
            m_id1   = (m_alloc + 1) % DEPTH;
            m_alloc += n;
        end else if (alloc_ready) begin
            m_valid = 0; m_mask = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        pkg_valid = 0; pkg_mask = 0; commit_valid = 0; commit_cnt = 0; flush = 0;
    endtask

    task automatic offer(input logic [1:0] mask);
        pkg_valid = 1; pkg_mask = mask; pkg[0] = $urandom; pkg[1] = $urandom;
    endtask

    task automatic drain();
        idle();
        alloc_ready = 1;
        while (m_alloc - m_ret > 0) begin
            commit_valid = 1;
            commit_cnt = 2'((m_alloc - m_ret) >= 2 ? 2 : 1);
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", alloc_valid); end
        checks++; if (alloc_mask !== 2'b00) begin errors++; $display("FAIL reset_mask got %b want 00", alloc_mask); end
        checks++; if (free_cnt !== 4'(DEPTH)) begin errors++; $display("FAIL reset_free got %0d want %0d", free_cnt, DEPTH); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (alloc !== '0 || alloc_id !== '0) begin errors++; $display("FAIL reset_data got %h/%h want 0", alloc, alloc_id); end
        rst_n = 1;
        m_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [1:0][PW-1:0] sent;
        alloc_ready = 1;
        offer(2'b11);
        sent = pkg;
        #1;
        checks++; if (pkg_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", pkg_ready); end
        tick();
        idle();
        checks++; if (alloc_valid !== 1'b1 || alloc_mask !== 2'b11) begin errors++; $display("FAIL basic_out got v=%b m=%b want v=1 m=11", alloc_valid, alloc_mask); end
        checks++; if (alloc_id[1] !== 3'd1 || alloc_id[0] !== 3'd0) begin errors++; $display("FAIL basic_ids got {%0d,%0d} want {1,0}", alloc_id[1], alloc_id[0]); end
        checks++; if (alloc !== sent) begin errors++; $display("FAIL basic_data got %h want %h", alloc, sent); end
        checks++; if (free_cnt !== 4'd6) begin errors++; $display("FAIL basic_free got %0d want 6", free_cnt); end
        tick();
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL basic_clear got %b want 0", alloc_valid); end
    endtask

    task automatic test_compact();
        logic [PW-1:0] s1;
        int free_before;
        alloc_ready = 1;
        offer(2'b10);
        s1 = pkg[1];
        tick();
        idle();
        checks++; if (alloc_valid !== 1'b1 || alloc_mask !== 2'b01) begin errors++; $display("FAIL compact_mask got v=%b m=%b want v=1 m=01", alloc_valid, alloc_mask); end
        checks++; if (alloc[0] !== s1) begin errors++; $display("FAIL compact_data got %h want %h", alloc[0], s1); end
        checks++; if (32'(alloc_id[0]) !== 32'(m_id0) || m_id0 != 2) begin errors++; $display("FAIL compact_id got %0d want 2", alloc_id[0]); end
        free_before = DEPTH - (m_alloc - m_ret);
        offer(2'b00);
        #1;
        checks++; if (pkg_ready !== 1'b1) begin errors++; $display("FAIL empty_mask_ready got %b want 1", pkg_ready); end
        tick();
        idle();
        checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL empty_mask_valid got %b want 0", alloc_valid); end
        checks++; if (32'(free_cnt) !== free_before) begin errors++; $display("FAIL empty_mask_free got %0d want %0d", free_cnt, free_before); end
        drain();
    endtask

    task automatic test_fill_wrap();
        int c;
        alloc_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            offer(2'b11);
            #1;
            checks++; if (pkg_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b want 1", k, pkg_ready); end
            tick();
            checks++; if (32'(free_cnt) !== DEPTH - 2*k) begin errors++; $display("FAIL fill_free%0d got %0d want %0d", k, free_cnt, DEPTH - 2*k); end
        end
        offer(2'b01);
        #1;
        checks++; if (pkg_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", pkg_ready); end
        pkg_valid = 0;
        commit_valid = 1; commit_cnt = 2;
        tick();
        idle();
        #1;
        checks++; if (free_cnt !== 4'd2) begin errors++; $display("FAIL commit_free got %0d want 2", free_cnt); end
        checks++; if (pkg_ready !== 1'b1) begin errors++; $display("FAIL commit_ready got %b want 1", pkg_ready); end
        for (int i = 0; i < 20; i++) begin
            offer(2'($urandom_range(1, 3)));
            c = m_alloc - m_ret;
            commit_valid = 1;
            commit_cnt = 2'($urandom_range(0, c < 2 ? c : 2));
            tick();
            checks++; if (32'(free_cnt) !== DEPTH - (m_alloc - m_ret) || free_cnt > 4'(DEPTH)) begin errors++; $display("FAIL wrap_free got %0d want %0d", free_cnt, DEPTH - (m_alloc - m_ret)); end
            if (m_valid) begin
                checks++; if (32'(alloc_id[0]) !== m_id0 || (m_mask == 2'b11 && 32'(alloc_id[1]) !== m_id1)) begin errors++; $display("FAIL wrap_id got {%0d,%0d} want {%0d,%0d}", alloc_id[1], alloc_id[0], m_id1, m_id0); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [1:0][PW-1:0] held;
        logic [1:0][IW-1:0] held_id;
        alloc_ready = 0;
        offer(2'b11);
        tick();
        held = alloc; held_id = alloc_id;
        offer(2'b11);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pkg_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got %b want 0", pkg_ready); end
            tick();
            checks++; if (alloc_valid !== 1'b1 || alloc !== held || alloc_id !== held_id) begin errors++; $display("FAIL hold_stable got %h/%h want %h/%h", alloc, alloc_id, held, held_id); end
        end
        alloc_ready = 1;
        #1;
        checks++; if (pkg_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", pkg_ready); end
        tick();
        idle();
        checks++; if (alloc_valid !== 1'b1 || alloc[0] !== m_d0 || alloc[1] !== m_d1 || 32'(alloc_id[0]) !== m_id0) begin errors++; $display("FAIL release_data got %h id %0d want %h id %0d", alloc, alloc_id[0], {m_d1, m_d0}, m_id0); end
        drain();
    endtask

    task automatic test_flush();
        rst_n = 0; #1; rst_n = 1; m_reset();
        @(posedge clk); #1;
        alloc_ready = 1;
        for (int k = 0; k < 3; k++) begin offer(2'b11); tick(); end
        offer(2'b11);
        flush = 1; commit_valid = 1; commit_cnt = 2;
        #1;
        checks++; if (pkg_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", pkg_ready); end
        tick();
        idle();
        checks++; if (free_cnt !== 4'd8 || empty !== 1'b1 || alloc_valid !== 1'b0) begin errors++; $display("FAIL flush_state got free=%0d empty=%b v=%b want 8 1 0", free_cnt, empty, alloc_valid); end
        offer(2'b01);
        tick();
        idle();
        checks++; if (alloc_id[0] !== 3'd2) begin errors++; $display("FAIL flush_tail got %0d want 2", alloc_id[0]); end
        drain();
    endtask

    task automatic test_async_reset();
        alloc_ready = 0;
        offer(2'b11);
        tick();
        idle();
        #3;
        rst_n = 0;
        #1;
        checks++; if (alloc_valid !== 1'b0 || alloc_mask !== 2'b00 || free_cnt !== 4'd8 || empty !== 1'b1) begin errors++; $display("FAIL async_reset got v=%b m=%b free=%0d empty=%b", alloc_valid, alloc_mask, free_cnt, empty); end
        #1;
        rst_n = 1;
        m_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 400; i++) begin
            pkg_valid = 1'($urandom_range(0, 3) != 0);
            pkg_mask = 2'($urandom);
            pkg[0] = $urandom; pkg[1] = $urandom;
            alloc_ready = 1'($urandom_range(0, 3) != 0);
            c = m_alloc - m_ret;
            commit_valid = 1'($urandom);
            commit_cnt = 2'($urandom_range(0, c < 2 ? c : 2));
            flush = ($urandom_range(0, 15) == 0);
            #1;
            checks++; if (pkg_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready cycle %0d got %b want %b", i, pkg_ready, m_ready()); end
            tick();
            checks++; if (alloc_valid !== m_valid || alloc_mask !== m_mask) begin errors++; $display("FAIL rnd_out cycle %0d got v=%b m=%b want v=%b m=%b", i, alloc_valid, alloc_mask, m_valid, m_mask); end
            checks++; if (32'(free_cnt) !== DEPTH - (m_alloc - m_ret) || empty !== (m_alloc == m_ret)) begin errors++; $display("FAIL rnd_occ cycle %0d got free=%0d empty=%b want %0d", i, free_cnt, empty, DEPTH - (m_alloc - m_ret)); end
            if (m_valid) begin
                checks++; if (alloc[0] !== m_d0 || 32'(alloc_id[0]) !== m_id0) begin errors++; $display("FAIL rnd_slot0 cycle %0d got %h id %0d want %h id %0d", i, alloc[0], alloc_id[0], m_d0, m_id0); end
                if (m_mask == 2'b11) begin
                    checks++; if (alloc[1] !== m_d1 || 32'(alloc_id[1]) !== m_id1) begin errors++; $display("FAIL rnd_slot1 cycle %0d got %h id %0d want %h id %0d", i, alloc[1], alloc_id[1], m_d1, m_id1); end
                end
            end
        end
        idle();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_compact();
        test_fill_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end
endmodule
